// File: rtl/key_event_encoder_if.sv
// key_event_encoder_if
//   Bundles the raw key/button inputs and the encoded note/event outputs of
//   key_event_encoder so they travel as one port.
//   Inputs  : iKeys[11:0], iOctUp, iOctDn, iAdsrUp, iAdsrDn, iAdsrSel[2:0]
//   Outputs : oNote[3:0], oNoteIn, oOctavePlusPlus, oOctaveMinusMinus,
//             oAdsrPlusPlus, oAdsrMinusMinus, oAdsrSelector[2:0], oOctave[2:0]
//   master drives the raw inputs and observes the outputs; slave is the encoder.
interface key_event_encoder_if;
   logic [11:0] iKeys;
   logic        iOctUp;
   logic        iOctDn;
   logic        iAdsrUp;
   logic        iAdsrDn;
   logic [2:0]  iAdsrSel;
   logic [3:0]  oNote;
   logic        oNoteIn;
   logic        oOctavePlusPlus;
   logic        oOctaveMinusMinus;
   logic        oAdsrPlusPlus;
   logic        oAdsrMinusMinus;
   logic [2:0]  oAdsrSelector;
   logic [2:0]  oOctave;

   modport master (
      output iKeys, iOctUp, iOctDn, iAdsrUp, iAdsrDn, iAdsrSel,
      input  oNote, oNoteIn, oOctavePlusPlus, oOctaveMinusMinus,
             oAdsrPlusPlus, oAdsrMinusMinus, oAdsrSelector, oOctave
   );

   modport slave (
      input  iKeys, iOctUp, iOctDn, iAdsrUp, iAdsrDn, iAdsrSel,
      output oNote, oNoteIn, oOctavePlusPlus, oOctaveMinusMinus,
             oAdsrPlusPlus, oAdsrMinusMinus, oAdsrSelector, oOctave
   );
endinterface

// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Turns 12 raw note keys and 4 raw push buttons into a latched note code,
//   a note-held level, single-cycle octave/ADSR event pulses and a 0..6
//   octave register. Every raw bit is 2-flop synchronised; keys and buttons
//   are then debounced individually. The ADSR select switches are only
//   synchronised.
//   Ports:
//     iClock  : sole clock, rising edge
//     iResetn : synchronous active-low reset
//     bus     : key_event_encoder_if.slave (raw inputs in, events out)
module key_event_encoder #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
   parameter logic [5:0]  GAP_CYCLES      = 6'd32
) (
   input  logic               iClock,
   input  logic               iResetn,
   key_event_encoder_if.slave bus
);

   localparam int NB = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HELD = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   // bit 11..0 = keys, 12 = oct up, 13 = oct down, 14 = adsr up, 15 = adsr down
   logic [NB-1:0] raw;
   assign raw = {bus.iAdsrDn, bus.iAdsrUp, bus.iOctDn, bus.iOctUp, bus.iKeys};

   logic [NB-1:0] sync1_q, sync2_q;
   logic [2:0]    sel1_q, sel2_q;

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sel1_q  <= '0;
         sel2_q  <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         sel1_q  <= bus.iAdsrSel;
         sel2_q  <= sel1_q;
      end
   end

   // Debounce: count consecutive disagreeing cycles; the cycle the count
   // would reach DEBOUNCE_CYCLES flips the output and clears the count.
   logic [19:0]   cnt_q [NB];
   logic [19:0]   cnt_d [NB];
   logic [NB-1:0] db_q, db_d;

   always_comb begin
      db_d = db_q;
      for (int k = 0; k < NB; k++) begin
         cnt_d[k] = '0;
         if (sync2_q[k] != db_q[k]) begin
            if (cnt_q[k] + 20'd1 == DEBOUNCE_CYCLES) db_d[k] = ~db_q[k];
            else                                     cnt_d[k] = cnt_q[k] + 20'd1;
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         db_q <= '0;
         for (int k = 0; k < NB; k++) cnt_q[k] <= '0;
      end else begin
         db_q <= db_d;
         for (int k = 0; k < NB; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   // Note FSM
   logic [1:0] state_q, state_d;
   logic [3:0] note_q, note_d;
   logic       note_in_q, note_in_d;
   logic [5:0] gap_q, gap_d;
   logic [3:0] lowest_key;

   always_comb begin
      lowest_key = 4'd0;
      for (int k = 11; k >= 0; k--)
         if (db_q[k]) lowest_key = 4'(k);
   end

   always_comb begin
      state_d   = state_q;
      note_d    = note_q;
      note_in_d = note_in_q;
      gap_d     = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (|db_q[11:0]) begin
               note_d    = lowest_key;
               note_in_d = 1'b1;
               state_d   = ST_HELD;
            end
         end
         ST_HELD: begin
            // only the latched key matters; db_q is 16 wide so a 4-bit index is exact
            if (!db_q[note_q]) begin
               note_in_d = 1'b0;
               gap_d     = GAP_CYCLES;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            // leaving on count <= 1 gives exactly GAP_CYCLES cycles in GAP
            if (gap_q <= 6'd1) state_d = ST_IDLE;
            else               gap_d   = gap_q - 6'd1;
         end
         default: begin
            state_d   = ST_IDLE;
            note_in_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         state_q   <= ST_IDLE;
         note_q    <= '0;
         note_in_q <= 1'b0;
         gap_q     <= '0;
      end else begin
         state_q   <= state_d;
         note_q    <= note_d;
         note_in_q <= note_in_d;
         gap_q     <= gap_d;
      end
   end

   // Button events: rising edge of debounced level, opposing pair cancels
   logic [3:0] btn_prev_q;
   logic [3:0] rise;
   logic [3:0] pulse_q, pulse_d;
   logic [2:0] oct_q, oct_d;

   assign rise = db_q[15:12] & ~btn_prev_q;

   always_comb begin
      pulse_d = '0;
      oct_d   = oct_q;
      if (rise[0] && !rise[1] && oct_q < 3'd6) begin
         oct_d      = oct_q + 3'd1;
         pulse_d[0] = 1'b1;
      end
      if (rise[1] && !rise[0] && oct_q > 3'd0) begin
         oct_d      = oct_q - 3'd1;
         pulse_d[1] = 1'b1;
      end
      pulse_d[2] = rise[2] & ~rise[3];
      pulse_d[3] = rise[3] & ~rise[2];
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         btn_prev_q <= '0;
         pulse_q    <= '0;
         oct_q      <= 3'd3;
      end else begin
         btn_prev_q <= db_q[15:12];
         pulse_q    <= pulse_d;
         oct_q      <= oct_d;
      end
   end

   assign bus.oNote             = note_q;
   assign bus.oNoteIn           = note_in_q;
   assign bus.oOctavePlusPlus   = pulse_q[0];
   assign bus.oOctaveMinusMinus = pulse_q[1];
   assign bus.oAdsrPlusPlus     = pulse_q[2];
   assign bus.oAdsrMinusMinus   = pulse_q[3];
   assign bus.oAdsrSelector     = sel2_q;
   assign bus.oOctave           = oct_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder
//   Drives key_event_encoder (DEBOUNCE_CYCLES=4, GAP_CYCLES=4) through a
//   vector table of note scenarios, hand-written button/reset sequences and
//   a randomized phase, comparing against a behavioural model every cycle.
module tb_key_event_encoder;

   localparam logic [19:0] D = 20'd4;
   localparam logic [5:0]  G = 6'd4;

   logic clk = 1'b0;
   logic rstn;

   key_event_encoder_if kif ();

   key_event_encoder #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G)) dut (
      .iClock  (clk),
      .iResetn (rstn),
      .bus     (kif.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int unsigned m_cyc = 0;
   logic [15:0] m_s1, m_s2, m_db, m_prev;
   int          m_streak [16];
   int          m_phase;       // 0 waiting for key, 1 key held, 2 quiet gap
   int unsigned m_gap_end;
   int          m_note;
   logic        m_in, m_opp, m_omm, m_app, m_amm;
   int          m_oct;
   logic [2:0]  m_sel1, m_sel2;

   always @(posedge clk) begin : ref_model
      logic [15:0] raw, db_o, rise;
      raw = {kif.iAdsrDn, kif.iAdsrUp, kif.iOctDn, kif.iOctUp, kif.iKeys};
      m_cyc++;
      if (!rstn) begin
         m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0;
         for (int k = 0; k < 16; k++) m_streak[k] = 0;
         m_phase = 0; m_note = 0; m_in = 1'b0;
         m_opp = 1'b0; m_omm = 1'b0; m_app = 1'b0; m_amm = 1'b0;
         m_oct = 3; m_sel1 = '0; m_sel2 = '0;
      end else begin
         db_o = m_db;
         for (int k = 0; k < 16; k++) begin
            if (m_s2[k] != db_o[k]) begin
               m_streak[k]++;
               if (m_streak[k] == int'(D)) begin
                  m_db[k] = ~m_db[k];
                  m_streak[k] = 0;
               end
            end else m_streak[k] = 0;
         end
         case (m_phase)
            0: if (db_o[11:0] != 12'd0) begin
                  for (int k = 11; k >= 0; k--) if (db_o[k]) m_note = k;
                  m_in = 1'b1;
                  m_phase = 1;
               end
            1: if (!db_o[m_note]) begin
                  m_in = 1'b0;
                  m_phase = 2;
                  m_gap_end = m_cyc + int'(G);
               end
            default: if (m_cyc == m_gap_end) m_phase = 0;
         endcase
         rise = db_o & ~m_prev;
         m_prev = db_o;
         m_opp = 1'b0; m_omm = 1'b0;
         if (rise[12] && !rise[13] && m_oct < 6) begin m_oct++; m_opp = 1'b1; end
         if (rise[13] && !rise[12] && m_oct > 0) begin m_oct--; m_omm = 1'b1; end
         m_app = rise[14] && !rise[15];
         m_amm = rise[15] && !rise[14];
         m_s2 = m_s1;
         m_s1 = raw;
         m_sel2 = m_sel1;
         m_sel1 = kif.iAdsrSel;
      end
   end

   bit mon_en = 1'b0;
   logic [14:0] dut_vec, exp_vec;

   always @(negedge clk) begin
      if (mon_en) begin
         dut_vec = {kif.oNote, kif.oNoteIn, kif.oOctavePlusPlus, kif.oOctaveMinusMinus,
                    kif.oAdsrPlusPlus, kif.oAdsrMinusMinus, kif.oAdsrSelector, kif.oOctave};
         exp_vec = {4'(m_note), m_in, m_opp, m_omm, m_app, m_amm, m_sel2, 3'(m_oct)};
         checks++;
         if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL model: dut=%h model=%h (t=%0t)", dut_vec, exp_vec, $time);
         end
      end
   end

   // ---------------- note scenario table ----------------
   typedef struct {
      logic [11:0] keys;
      int          waitn;
      logic [3:0]  exp_note;
      logic        exp_in;
   } vec_t;

   vec_t tbl [15];
   int exp_oct [4] = '{4, 5, 6, 6};
   int exp_opp [4] = '{1, 1, 1, 0};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pc;
      int b;
      tbl[0]  = '{12'h010,  6, 4'd0, 1'b0};
      tbl[1]  = '{12'h010,  1, 4'd4, 1'b1};
      tbl[2]  = '{12'h000,  6, 4'd4, 1'b1};
      tbl[3]  = '{12'h000,  1, 4'd4, 1'b0};
      tbl[4]  = '{12'h000,  4, 4'd4, 1'b0};
      tbl[5]  = '{12'h0A0,  7, 4'd5, 1'b1};
      tbl[6]  = '{12'h080,  7, 4'd5, 1'b0};
      tbl[7]  = '{12'h080,  4, 4'd5, 1'b0};
      tbl[8]  = '{12'h080,  1, 4'd7, 1'b1};
      tbl[9]  = '{12'h000, 12, 4'd7, 1'b0};
      tbl[10] = '{12'h001,  3, 4'd7, 1'b0};
      tbl[11] = '{12'h000, 10, 4'd7, 1'b0};
      tbl[12] = '{12'h001,  6, 4'd7, 1'b0};
      tbl[13] = '{12'h001,  1, 4'd0, 1'b1};
      tbl[14] = '{12'h000, 12, 4'd0, 1'b0};

      rstn = 1'b0;
      kif.iKeys = '0; kif.iOctUp = 1'b0; kif.iOctDn = 1'b0;
      kif.iAdsrUp = 1'b0; kif.iAdsrDn = 1'b0; kif.iAdsrSel = '0;
      repeat (3) @(negedge clk);
      chk("rst.note",   int'(kif.oNote), 0);
      chk("rst.notein", int'(kif.oNoteIn), 0);
      chk("rst.octave", int'(kif.oOctave), 3);
      chk("rst.sel",    int'(kif.oAdsrSelector), 0);
      chk("rst.pulses", int'({kif.oOctavePlusPlus, kif.oOctaveMinusMinus,
                              kif.oAdsrPlusPlus, kif.oAdsrMinusMinus}), 0);
      mon_en = 1'b1;
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         kif.iKeys = tbl[i].keys;
         repeat (tbl[i].waitn) @(negedge clk);
         chk($sformatf("vec%0d.note", i),   int'(kif.oNote),   int'(tbl[i].exp_note));
         chk($sformatf("vec%0d.notein", i), int'(kif.oNoteIn), int'(tbl[i].exp_in));
      end

      // four octave-up presses from octave 3
      for (int p = 0; p < 4; p++) begin
         kif.iOctUp = 1'b1;
         repeat (6) @(negedge clk);
         chk($sformatf("octup%0d.early", p), int'(kif.oOctavePlusPlus), 0);
         @(negedge clk);
         chk($sformatf("octup%0d.pulse", p), int'(kif.oOctavePlusPlus), exp_opp[p]);
         chk($sformatf("octup%0d.octave", p), int'(kif.oOctave), exp_oct[p]);
         pc = 0;
         repeat (12) begin @(negedge clk); pc += int'(kif.oOctavePlusPlus); end
         chk($sformatf("octup%0d.norepeat", p), pc, 0);
         kif.iOctUp = 1'b0;
         repeat (10) @(negedge clk);
      end

      kif.iOctDn = 1'b1;
      repeat (7) @(negedge clk);
      chk("octdn.pulse",  int'(kif.oOctaveMinusMinus), 1);
      chk("octdn.octave", int'(kif.oOctave), 5);
      kif.iOctDn = 1'b0;
      repeat (10) @(negedge clk);

      // simultaneous opposing presses cancel
      kif.iOctUp = 1'b1; kif.iOctDn = 1'b1;
      pc = 0;
      repeat (14) begin @(negedge clk); pc += int'(kif.oOctavePlusPlus) + int'(kif.oOctaveMinusMinus); end
      chk("octboth.pulses", pc, 0);
      chk("octboth.octave", int'(kif.oOctave), 5);
      kif.iOctUp = 1'b0; kif.iOctDn = 1'b0;
      repeat (10) @(negedge clk);

      kif.iAdsrUp = 1'b1; kif.iAdsrDn = 1'b1;
      pc = 0;
      repeat (14) begin @(negedge clk); pc += int'(kif.oAdsrPlusPlus) + int'(kif.oAdsrMinusMinus); end
      chk("adsrboth.pulses", pc, 0);
      kif.iAdsrUp = 1'b0; kif.iAdsrDn = 1'b0;
      repeat (10) @(negedge clk);

      kif.iAdsrDn = 1'b1;
      pc = 0;
      repeat (14) begin @(negedge clk); pc += int'(kif.oAdsrMinusMinus); end
      chk("adsrdn.onepulse", pc, 1);
      kif.iAdsrDn = 1'b0;
      repeat (10) @(negedge clk);

      kif.iAdsrSel = 3'b101;
      @(negedge clk);
      chk("sel.lat1", int'(kif.oAdsrSelector), 0);
      @(negedge clk);
      chk("sel.lat2", int'(kif.oAdsrSelector), 5);

      // reset while a key is held
      kif.iKeys = 12'h004;
      repeat (7) @(negedge clk);
      chk("rsthold.notein", int'(kif.oNoteIn), 1);
      chk("rsthold.note",   int'(kif.oNote), 2);
      rstn = 1'b0;
      @(negedge clk);
      chk("rsthold.drop",   int'(kif.oNoteIn), 0);
      chk("rsthold.rnote",  int'(kif.oNote), 0);
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      chk("rsthold.early",  int'(kif.oNoteIn), 0);
      @(negedge clk);
      chk("rsthold.again",  int'(kif.oNoteIn), 1);
      chk("rsthold.anote",  int'(kif.oNote), 2);
      kif.iKeys = '0;
      repeat (12) @(negedge clk);

      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0) begin
            b = int'($urandom_range(0, 11));
            kif.iKeys[b] = ~kif.iKeys[b];
         end
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0: kif.iOctUp  = ~kif.iOctUp;
               1: kif.iOctDn  = ~kif.iOctDn;
               2: kif.iAdsrUp = ~kif.iAdsrUp;
               default: kif.iAdsrDn = ~kif.iAdsrDn;
            endcase
         end
         if ($urandom_range(0, 60) == 0) begin
            kif.iOctUp = 1'b1; kif.iOctDn = 1'b1;
            kif.iAdsrUp = 1'b1; kif.iAdsrDn = 1'b1;
         end
         if ($urandom_range(0, 15) == 0) kif.iAdsrSel = 3'($urandom);
         rstn = ($urandom_range(0, 599) != 0);
      end
      rstn = 1'b1;
      kif.iKeys = '0; kif.iOctUp = 1'b0; kif.iOctDn = 1'b0;
      kif.iAdsrUp = 1'b0; kif.iAdsrDn = 1'b0;
      repeat (20) @(negedge clk);
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_event_encoder.md
KEY_EVENT_ENCODER -- requirements
Module: key_event_encoder

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 20'd500000; number of consecutive disagreeing cycles required before a debounced input changes (10 ms at 50 MHz).
- REQ-002: Parameter GAP_CYCLES, default 6'd32; cycles oNote is held stable with oNoteIn low after a note release.
- REQ-003: iClock  input  1  sole clock; all state updates on posedge.
- REQ-004: iResetn  input  1  reset, synchronous, active-low.
- REQ-005: iKeys  input  12  raw note keys, asynchronous; bit k = semitone k (0 = C … 11 = B).
- REQ-006: iOctUp, iOctDn, iAdsrUp, iAdsrDn  input  1 each  raw asynchronous push buttons, active-high.
- REQ-007: iAdsrSel  input  3  raw ADSR parameter select switches.
- REQ-008: oNote  output  4  latched note code 0..11, feeds the display and tone stages.
- REQ-009: oNoteIn  output  1  level, high while the latched key is held.
- REQ-010: oOctavePlusPlus, oOctaveMinusMinus, oAdsrPlusPlus, oAdsrMinusMinus  output  1 each  single-cycle event pulses.
- REQ-011: oAdsrSelector  output  3  synchronised copy of iAdsrSel.
- REQ-012: oOctave  output  3  current octave, range 0..6.

Function
- REQ-013: Every raw input bit shall pass through a 2-flop synchroniser; raw change at edge t is visible as synced value at edge t+2.
- REQ-014: Each of the 16 key/button bits shall have its own debouncer: a counter that increments while synced != debounced, clears to 0 when they are equal, and toggles the debounced bit (clearing the counter) on the cycle the count would reach DEBOUNCE_CYCLES.
- REQ-015: Debounce latency: raw stable from edge t → debounced change at edge t+2+DEBOUNCE_CYCLES; any glitch shorter than DEBOUNCE_CYCLES shall produce no change.
- REQ-016: oAdsrSelector = synced iAdsrSel (no debounce), latency 2 cycles.
- REQ-017: Note FSM states: IDLE, HELD, GAP.
- REQ-018: IDLE: if any debounced key is high, latch the lowest-index high key into oNote, set oNoteIn=1 on the same edge, go HELD; else stay.
- REQ-019: HELD: oNote frozen; other keys pressed or released are ignored; when the latched key's debounced bit goes low, set oNoteIn=0, load the gap counter, go GAP.
- REQ-020: GAP: oNoteIn=0, oNote unchanged for exactly GAP_CYCLES cycles regardless of key activity; then go IDLE.
- REQ-021: Key-to-oNoteIn latency: DEBOUNCE_CYCLES+3 edges from raw assertion.
- REQ-022: On a debounced rising edge of a button, emit a one-cycle pulse on the matching output on the following edge.
- REQ-023: If iOctUp and iOctDn debounced rising edges occur in the same cycle, neither octave pulse fires and oOctave is unchanged; the same rule applies to iAdsrUp/iAdsrDn.
- REQ-024: oOctave increments on an up event and decrements on a down event, saturating at 6 and 0.
- REQ-025: An octave event at saturation shall produce no pulse.
- REQ-026: ADSR pulses shall not saturate.
- REQ-027: Held buttons shall produce exactly one pulse per press; no auto-repeat.
- REQ-028: Pulse outputs shall never be high for two consecutive cycles.

Reset
- REQ-029: While iResetn=0 at an edge: oNote=0, oNoteIn=0, all pulses=0, oAdsrSelector=0, oOctave=3, FSM=IDLE, all synchroniser/debounced bits=0, all counters=0.
- REQ-030: Reset asserted mid-HELD or mid-GAP shall drop oNoteIn on that edge; after release, a still-held key shall re-trigger only after full re-debounce (REQ-015).
- REQ-031: A key or button already high when reset releases shall be treated as a new press after debounce.

Verification (DEBOUNCE_CYCLES=4, GAP_CYCLES=4)
- REQ-032: iKeys=12'h010 from edge 10 → oNote=4, oNoteIn=1 at edge 17; release → oNoteIn=0, oNote held at 4 for 4 cycles, then IDLE.
- REQ-033: iKeys=12'h0A0 → oNote=5; then iKeys=12'h080 while HELD → oNoteIn falls after debounce, GAP, then oNote=7 re-asserts.
- REQ-034: 3-cycle glitch on iKeys[0] → oNoteIn stays 0, debounce counter returns to 0.
- REQ-035: Four iOctUp presses from reset → oOctave 4,5,6,6 with three one-cycle pulses and none on the fourth.
- REQ-036: iAdsrUp and iAdsrDn asserted on the same edge → no ADSR pulses; iAdsrSel=3'b101 → oAdsrSelector=5 two cycles later.
- REQ-037: Reset pulsed during HELD with key held → oNoteIn=0 at the reset edge, re-asserts DEBOUNCE_CYCLES+3 edges after reset release.
